// File: rtl/sdram_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_if_pkg
// Desc     : Shared constants and writer state encoding for the SDRAM bridge
// Revision : 1.0 - initial release
// ============================================================================
package sdram_if_pkg;

    localparam int c_INTERFACE_WIDTH_BITS = 128;
    localparam int c_INTERFACE_ADDR_BITS  = 26;
    localparam int c_WORD_BITS            = 32;
    localparam int c_BEAT_BYTES           = 16;
    localparam int c_ACK_TIMEOUT          = 1024;

    typedef logic [1:0] writer_state_t;

    localparam writer_state_t c_ST_IDLE  = 2'd0;
    localparam writer_state_t c_ST_FILL  = 2'd1;
    localparam writer_state_t c_ST_WRITE = 2'd2;
    localparam writer_state_t c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sdram_result_writer_beat_packer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_result_writer_beat_packer
// Desc     : Packs input words into one bridge beat with per-lane byte enables
// Revision : 1.0 - initial release
// ============================================================================
module sdram_result_writer_beat_packer
    import sdram_if_pkg::*;
#(
    parameter int WIDTH_BITS = c_INTERFACE_WIDTH_BITS,
    parameter int WORD_BITS  = c_WORD_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_clear,
    input  logic                                      i_accept,
    input  logic [WORD_BITS-1:0]                      i_word,
    output logic [WIDTH_BITS-1:0]                     o_data,
    output logic [WIDTH_BITS/8-1:0]                   o_byte_enable,
    output logic [$clog2(WIDTH_BITS/WORD_BITS+1)-1:0] o_lane_count,
    output logic                                      o_last_lane
);

    localparam int c_WORDS      = WIDTH_BITS / WORD_BITS;
    localparam int c_WORD_BYTES = WORD_BITS / 8;
    localparam int c_LANE_BITS  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_COUNT_BITS = $clog2(c_WORDS + 1);

    logic [c_LANE_BITS-1:0]  r_lane;
    logic [WIDTH_BITS-1:0]   r_data;
    logic [WIDTH_BITS/8-1:0] r_be;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane <= '0;
            r_data <= '0;
            r_be   <= '0;
        end else if (i_accept) begin
            for (int i = 0; i < c_WORDS; i++) begin
                if (r_lane == c_LANE_BITS'(i)) begin
                    r_data[i*WORD_BITS +: WORD_BITS]    <= i_word;
                    r_be[i*c_WORD_BYTES +: c_WORD_BYTES] <= '1;
                end
            end
            r_lane <= r_lane + 1'b1;
        end
    end

    // Lanes fill in order, so one enable bit per lane is enough to count them.
    always_comb begin
        o_lane_count = '0;
        for (int i = 0; i < c_WORDS; i++) begin
            o_lane_count = o_lane_count + {{(c_COUNT_BITS-1){1'b0}}, r_be[i*c_WORD_BYTES]};
        end
    end

    assign o_last_lane   = i_accept && (r_lane == c_LANE_BITS'(c_WORDS - 1));
    assign o_data        = r_data;
    assign o_byte_enable = r_be;

endmodule
`default_nettype wire

// File: rtl/sdram_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_result_writer
// Desc     : Streams 32-bit results into 128-bit beats written to SDRAM
// Revision : 1.0 - initial release
// ============================================================================
module sdram_result_writer
    import sdram_if_pkg::*;
#(
    parameter int INTERFACE_WIDTH_BITS = c_INTERFACE_WIDTH_BITS,
    parameter int INTERFACE_ADDR_BITS  = c_INTERFACE_ADDR_BITS,
    parameter int WORD_BITS            = c_WORD_BITS,
    parameter int ACK_TIMEOUT          = c_ACK_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
    input  logic                              word_valid,
    input  logic [WORD_BITS-1:0]              word_data,
    output logic                              word_ready,
    input  logic                              flush,
    output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
    output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
    output logic                              interface_write,
    output logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data,
    input  logic                              interface_acknowledge,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout_error,
    output logic [15:0]                       words_written
);

    localparam int c_WORDS_PER_BEAT = INTERFACE_WIDTH_BITS / WORD_BITS;
    localparam int c_COUNT_BITS     = $clog2(c_WORDS_PER_BEAT + 1);
    localparam int c_TIMER_BITS     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    writer_state_t                  r_state;
    writer_state_t                  w_state_next;
    logic [INTERFACE_ADDR_BITS-1:0] r_addr;
    logic                           r_flush_pending;
    logic                           r_timeout_error;
    logic [15:0]                    r_words_written;
    logic [c_TIMER_BITS-1:0]        r_timer;

    logic                              w_accept;
    logic                              w_ack;
    logic                              w_timeout;
    logic                              w_clear;
    logic                              w_last_lane;
    logic [c_COUNT_BITS-1:0]           w_lane_count;
    logic [INTERFACE_WIDTH_BITS-1:0]   w_beat_data;
    logic [INTERFACE_WIDTH_BITS/8-1:0] w_beat_be;

    assign w_accept  = (r_state == c_ST_FILL) && word_valid;
    assign w_ack     = (r_state == c_ST_WRITE) && interface_acknowledge;
    assign w_timeout = (r_state == c_ST_WRITE) && !interface_acknowledge
                       && (r_timer == c_TIMER_BITS'(ACK_TIMEOUT - 1));
    // A committed or discarded beat leaves the packer empty for the next one.
    assign w_clear   = ((r_state == c_ST_IDLE) && start) || w_ack || w_timeout;

    sdram_result_writer_beat_packer #(
        .WIDTH_BITS (INTERFACE_WIDTH_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_beat_packer (
        .clk           (clk),
        .rst           (reset),
        .i_clear       (w_clear),
        .i_accept      (w_accept),
        .i_word        (word_data),
        .o_data        (w_beat_data),
        .o_byte_enable (w_beat_be),
        .o_lane_count  (w_lane_count),
        .o_last_lane   (w_last_lane)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_next = c_ST_FILL;
            end
            c_ST_FILL: begin
                if (w_last_lane) begin
                    w_state_next = c_ST_WRITE;
                end else if (flush) begin
                    w_state_next = (w_accept || (w_beat_be != '0)) ? c_ST_WRITE : c_ST_DONE;
                end
            end
            c_ST_WRITE: begin
                // A flush landing in the acknowledge cycle still ends the run.
                if (w_ack) begin
                    w_state_next = (r_flush_pending || flush) ? c_ST_DONE : c_ST_FILL;
                end else if (w_timeout) begin
                    w_state_next = c_ST_DONE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_addr          <= '0;
            r_flush_pending <= 1'b0;
            r_timeout_error <= 1'b0;
            r_words_written <= '0;
            r_timer         <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= ((r_state == c_ST_WRITE) && (w_state_next == c_ST_WRITE))
                       ? r_timer + 1'b1 : '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_addr          <= base_address;
                        r_flush_pending <= 1'b0;
                        r_timeout_error <= 1'b0;
                        r_words_written <= '0;
                    end
                end
                c_ST_FILL: begin
                    if (flush) r_flush_pending <= 1'b1;
                end
                c_ST_WRITE: begin
                    if (flush) r_flush_pending <= 1'b1;
                    if (interface_acknowledge) begin
                        r_addr          <= r_addr + INTERFACE_ADDR_BITS'(c_BEAT_BYTES);
                        r_words_written <= r_words_written + 16'(w_lane_count);
                    end else if (w_timeout) begin
                        r_timeout_error <= 1'b1;
                    end
                end
                default: r_flush_pending <= 1'b0;
            endcase
        end
    end

    assign word_ready            = (r_state == c_ST_FILL);
    assign interface_write       = (r_state == c_ST_WRITE);
    assign interface_address     = r_addr;
    assign interface_byte_enable = w_beat_be;
    assign interface_write_data  = w_beat_data;
    assign busy                  = (r_state != c_ST_IDLE);
    assign done                  = (r_state == c_ST_DONE);
    assign timeout_error         = r_timeout_error;
    assign words_written         = r_words_written;

endmodule
`default_nettype wire

// File: tb/tb_sdram_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_result_writer
// Desc     : Scoreboard bench for sdram_result_writer (ACK_TIMEOUT = 8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_result_writer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [25:0]  base_address;
    logic         word_valid;
    logic [31:0]  word_data;
    logic         word_ready;
    logic         flush;
    logic [25:0]  interface_address;
    logic [15:0]  interface_byte_enable;
    logic         interface_write;
    logic [127:0] interface_write_data;
    logic         interface_acknowledge;
    logic         busy;
    logic         done;
    logic         timeout_error;
    logic [15:0]  words_written;

    sdram_result_writer #(
        .ACK_TIMEOUT (8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .base_address          (base_address),
        .word_valid            (word_valid),
        .word_data             (word_data),
        .word_ready            (word_ready),
        .flush                 (flush),
        .interface_address     (interface_address),
        .interface_byte_enable (interface_byte_enable),
        .interface_write       (interface_write),
        .interface_write_data  (interface_write_data),
        .interface_acknowledge (interface_acknowledge),
        .busy                  (busy),
        .done                  (done),
        .timeout_error         (timeout_error),
        .words_written         (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [25:0]  addr;
        logic [127:0] data;
        logic [15:0]  be;
    } beat_t;

    beat_t        exp_q[$];
    logic [25:0]  m_addr;
    logic [127:0] m_data;
    logic [15:0]  m_be;
    int           m_lane;
    int           m_words;
    bit           m_discard;

    int n_checks   = 0;
    int n_errors   = 0;
    int ack_delay  = 0;
    bit ack_enable = 1'b1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_commit();
        beat_t b;
        if (!m_discard) begin
            b.addr = m_addr;
            b.data = m_data;
            b.be   = m_be;
            exp_q.push_back(b);
            m_words += m_lane;
            m_addr  += 26'h10;
        end
        m_lane = 0;
        m_data = '0;
        m_be   = '0;
    endtask

    task automatic model_accept(input logic [31:0] w);
        m_data[m_lane*32 +: 32] = w;
        m_be[m_lane*4 +: 4]     = 4'hF;
        m_lane++;
        if (m_lane == 4) model_commit();
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic start_run(input logic [25:0] b);
        start = 1'b1;
        base_address = b;
        m_addr = b; m_lane = 0; m_data = '0; m_be = '0; m_words = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit fl);
        int n = 0;
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!word_ready) begin
            check("word_ready_wait", word_ready, 1'b1);
            return;
        end
        word_valid = 1'b1;
        word_data  = w;
        flush      = fl;
        model_accept(w);
        if (fl && m_lane > 0) model_commit();
        @(negedge clk);
        word_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        if (m_lane > 0) model_commit();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    // Acknowledge responder: ack_delay extra write cycles, then a one-cycle pulse.
    initial begin
        interface_acknowledge = 1'b0;
        forever begin
            @(negedge clk);
            if (interface_write && ack_enable) begin
                repeat (ack_delay) @(negedge clk);
                interface_acknowledge = 1'b1;
                @(negedge clk);
                interface_acknowledge = 1'b0;
            end
        end
    end

    // Scoreboard: every acknowledged write must match the oldest expected beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (interface_write && interface_acknowledge) begin
                check("wr_expected_pending", 128'(exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("wr_addr", interface_address, b.addr);
                    check("wr_data", interface_write_data, b.data);
                    check("wr_be", interface_byte_enable, b.be);
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; base_address = '0; word_valid = 1'b0;
        word_data = '0; flush = 1'b0;
        m_addr = '0; m_data = '0; m_be = '0; m_lane = 0; m_words = 0; m_discard = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_write", interface_write, 1'b0);
        check("rst_ready", word_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout_error, 1'b0);
        check("rst_words", words_written, 16'd0);
        check("rst_addr", interface_address, 26'd0);
        check("rst_be", interface_byte_enable, 16'd0);
        check("rst_data", interface_write_data, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full beat, late acknowledge, then flush with nothing buffered.
        ack_delay = 3;
        start_run(26'h0000100);
        check("t1_busy", busy, 1'b1);
        check("t1_ready", word_ready, 1'b1);
        for (int i = 0; i < 4; i++) send_word(32'(32'h11111111 * (i + 1)), 1'b0);
        check("t1_write_latency", interface_write, 1'b1);
        wait_drain();
        check("t1_words", words_written, 16'd4);
        check("t1_back_to_fill", word_ready, 1'b1);
        pulse_flush();
        check("t3_done", done, 1'b1);
        check("t3_no_write", interface_write, 1'b0);
        @(negedge clk);
        check("t3_done_once", done, 1'b0);
        check("t3_busy_low", busy, 1'b0);

        // Partial flush after six words.
        ack_delay = 1;
        start_run(26'h0000200);
        for (int i = 0; i < 6; i++) send_word(32'hA0000001 + 32'(i), 1'b0);
        pulse_flush();
        wait_done();
        check("t2_words", words_written, 16'(m_words));
        check("t2_words_abs", words_written, 16'd6);
        check("t2_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("t2_done_once", done, 1'b0);
        check("t2_busy_low", busy, 1'b0);

        // Same-cycle ack, start during WRITE ignored, flush with the fifth word.
        ack_delay = 0;
        start_run(26'h0000400);
        for (int i = 0; i < 4; i++) send_word(32'hB0B0_0000 + 32'(i), 1'b0);
        start = 1'b1;
        base_address = 26'h0000800;
        @(negedge clk);
        start = 1'b0;
        send_word(32'hCAFE_F00D, 1'b1);
        wait_done();
        check("t4_words", words_written, 16'd5);
        check("t4_timeout", timeout_error, 1'b0);
        check("t4_queue_empty", exp_q.size(), 0);
        @(negedge clk);

        // Acknowledge never arrives.
        ack_enable = 1'b0;
        m_discard  = 1'b1;
        start_run(26'h0000600);
        for (int i = 0; i < 4; i++) send_word(32'hDEAD_0000 + 32'(i), 1'b0);
        n = 0;
        while (interface_write && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t5_write_cycles", n, 8);
        check("t5_done", done, 1'b1);
        check("t5_timeout", timeout_error, 1'b1);
        check("t5_words", words_written, 16'd0);
        @(negedge clk);
        check("t5_busy_low", busy, 1'b0);
        check("t5_sticky", timeout_error, 1'b1);
        m_discard = 1'b0;
        start_run(26'h0000700);
        check("t5_cleared_by_start", timeout_error, 1'b0);
        pulse_flush();
        check("t5_empty_done", done, 1'b1);
        @(negedge clk);
        ack_enable = 1'b1;

        // Address wrap across the top of the 26-bit space.
        ack_delay = 2;
        start_run(26'h3FFFFF0);
        for (int i = 0; i < 8; i++) send_word(32'h5000_0000 + 32'(i), 1'b0);
        wait_drain();
        check("t6_words", words_written, 16'd8);

        // Reset in the middle of a write drops it without waiting.
        ack_enable = 1'b0;
        m_discard  = 1'b1;
        for (int i = 0; i < 4; i++) send_word(32'h6000_0000 + 32'(i), 1'b0);
        check("t6_write_before_reset", interface_write, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_write", interface_write, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ready", word_ready, 1'b0);
        check("t6_rst_addr", interface_address, 26'd0);
        check("t6_rst_be", interface_byte_enable, 16'd0);
        check("t6_rst_data", interface_write_data, 128'd0);
        check("t6_rst_words", words_written, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
